thumb_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the pipelined Thumb core; feeds the decode stage.

---
 rtl/thumb_fetch_stage.sv | 99 +++++++++
 tb/tb_thumb_fetch_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/thumb_fetch_stage.sv
// Thumb instruction-fetch stage: drives the instruction memory port and buffers
// fetched halfwords in a small prefetch FIFO that feeds the decode stage.
module thumb_fetch_stage #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 16,
  parameter int unsigned            DEPTH       = 2,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   read_instruction_n,
  output logic [ADDR_WIDTH-1:0]  instruction_address,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   halt,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0]  if_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  halted, halted_next;
  logic                  push, pop, issue;
  logic [ADDR_WIDTH-1:0] next_pc, pc_base;

  always_comb begin
    pop  = (count != '0) && !stall && !branch_taken;
    push = !read_instruction_n && !branch_taken && ((count < FULL) || pop);

    count_next = count;
    if (branch_taken)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (pop && !push)
      count_next = count - CNT_W'(1);

    halted_next = halted | halt;
    issue       = !halted_next && (count_next < FULL);

    // next_pc remembers where to resume while fetching is paused by a full FIFO
    if (branch_taken)
      pc_base = branch_target & ~ADDR_WIDTH'(1);
    else if (!read_instruction_n)
      pc_base = instruction_address + ADDR_WIDTH'(2);
    else
      pc_base = next_pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_instruction_n  <= 1'b1;
      instruction_address <= RESET_PC;
      next_pc             <= RESET_PC;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      halted              <= 1'b0;
    end else begin
      halted             <= halted_next;
      count              <= count_next;
      read_instruction_n <= !issue;
      next_pc            <= pc_base;
      if (issue)
        instruction_address <= pc_base;
      if (branch_taken) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= instruction;
      pc_mem[wr_ptr]    <= instruction_address;
    end
  end

  always_comb begin
    if_valid = (count != '0);
    if_instr = if_valid ? instr_mem[rd_ptr] : '0;
    if_pc    = if_valid ? pc_mem[rd_ptr]    : '0;
  end

endmodule

// File: tb/tb_thumb_fetch_stage.sv
// Directed bench for thumb_fetch_stage with a combinational instruction memory model.
module tb_thumb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_instruction_n;
  logic [31:0] instruction_address;
  logic [15:0] instruction;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [31:0] if_pc;

  int total = 0;
  int bad   = 0;

  thumb_fetch_stage #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(16),
    .DEPTH      (2),
    .RESET_PC   (32'h0)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .read_instruction_n (read_instruction_n),
    .instruction_address(instruction_address),
    .instruction        (instruction),
    .stall              (stall),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .halt               (halt),
    .if_valid           (if_valid),
    .if_instr           (if_instr),
    .if_pc              (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 16'h2100;
      32'h2:   mem_word = 16'h2200;
      32'h4:   mem_word = 16'h20fc;
      default: mem_word = 16'h3000 | {4'h0, a[11:0]};
    endcase
  endfunction

  always_comb instruction = read_instruction_n ? 16'h0 : mem_word(instruction_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic rn, input logic [31:0] addr);
    chk({tag, ".rd_n"}, {31'h0, read_instruction_n}, {31'h0, rn});
    if (!rn) chk({tag, ".addr"}, instruction_address, addr);
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [15:0] ins, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'h0, if_valid}, {31'h0, v});
    chk({tag, ".instr"}, {16'h0, if_instr}, {16'h0, ins});
    chk({tag, ".pc"}, if_pc, pc);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
    tick(); tick();
    chk_fetch("rst", 1'b1, 32'h0);
    chk("rst.addr", instruction_address, 32'h0);
    chk_head("rst", 1'b0, 16'h0, 32'h0);

    // sequential fetch
    reset_n = 1'b1;
    tick(); chk_fetch("t1.e1", 1'b0, 32'h0); chk_head("t1.e1", 1'b0, 16'h0, 32'h0);
    tick(); chk_fetch("t1.e2", 1'b0, 32'h2); chk_head("t1.e2", 1'b1, 16'h2100, 32'h0);
    tick(); chk_fetch("t1.e3", 1'b0, 32'h4); chk_head("t1.e3", 1'b1, 16'h2200, 32'h2);
    tick(); chk_fetch("t1.e4", 1'b0, 32'h6); chk_head("t1.e4", 1'b1, 16'h20fc, 32'h4);

    // fill FIFO under stall, then asynchronous reset
    stall = 1'b1;
    tick(); chk_fetch("t5.full", 1'b1, 32'h0); chk_head("t5.full", 1'b1, 16'h20fc, 32'h4);
    #2 reset_n = 1'b0;
    #1 chk_fetch("t5.rst", 1'b1, 32'h0);
    chk("t5.rst.addr", instruction_address, 32'h0);
    chk_head("t5.rst", 1'b0, 16'h0, 32'h0);
    stall = 1'b0;
    tick();
    reset_n = 1'b1;

    // restart from RESET_PC, then stall for four edges
    tick(); chk_fetch("t2.e1", 1'b0, 32'h0);
    tick(); chk_fetch("t2.e2", 1'b0, 32'h2); chk_head("t2.e2", 1'b1, 16'h2100, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_fetch("t2.stall", 1'b1, 32'h0);
      chk_head("t2.stall", 1'b1, 16'h2100, 32'h0);
    end
    stall = 1'b0;
    tick(); chk_fetch("t2.r1", 1'b0, 32'h4); chk_head("t2.r1", 1'b1, 16'h2200, 32'h2);
    tick(); chk_fetch("t2.r2", 1'b0, 32'h6); chk_head("t2.r2", 1'b1, 16'h20fc, 32'h4);
    tick(); chk_fetch("t2.r3", 1'b0, 32'h8); chk_head("t2.r3", 1'b1, 16'h3006, 32'h6);
    tick(); chk_fetch("t2.r4", 1'b0, 32'ha); chk_head("t2.r4", 1'b1, 16'h3008, 32'h8);

    // branch with 0xa in flight
    branch_taken = 1'b1; branch_target = 32'h15;
    tick(); chk_fetch("t3.br", 1'b0, 32'h14); chk_head("t3.br", 1'b0, 16'h0, 32'h0);
    branch_taken = 1'b0;
    tick(); chk_fetch("t3.e1", 1'b0, 32'h16); chk_head("t3.e1", 1'b1, 16'h3014, 32'h14);

    // halt at the edge returning 0x16
    halt = 1'b1;
    tick(); chk_fetch("t4.h", 1'b1, 32'h0); chk_head("t4.h", 1'b1, 16'h3016, 32'h16);
    halt = 1'b0;
    tick(); chk_fetch("t4.d1", 1'b1, 32'h0); chk_head("t4.d1", 1'b0, 16'h0, 32'h0);
    tick(); chk_fetch("t4.d2", 1'b1, 32'h0);
    branch_taken = 1'b1; branch_target = 32'h20;
    tick(); chk_fetch("t4.sticky", 1'b1, 32'h0);
    branch_taken = 1'b0;
    tick(); chk_fetch("t4.sticky2", 1'b1, 32'h0); chk_head("t4.sticky2", 1'b0, 16'h0, 32'h0);

    // address wrap
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); chk_fetch("t6.e1", 1'b0, 32'h0);
    branch_taken = 1'b1; branch_target = 32'hFFFFFFFC;
    tick(); chk_fetch("t6.br", 1'b0, 32'hFFFFFFFC); chk_head("t6.br", 1'b0, 16'h0, 32'h0);
    branch_taken = 1'b0;
    tick(); chk_fetch("t6.a1", 1'b0, 32'hFFFFFFFE); chk_head("t6.a1", 1'b1, 16'h3FFC, 32'hFFFFFFFC);
    tick(); chk_fetch("t6.a2", 1'b0, 32'h0); chk_head("t6.a2", 1'b1, 16'h3FFE, 32'hFFFFFFFE);
    tick(); chk_fetch("t6.a3", 1'b0, 32'h2); chk_head("t6.a3", 1'b1, 16'h2100, 32'h0);

    // halt and branch on the same edge
    halt = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    tick(); chk_fetch("hb.e1", 1'b1, 32'h0); chk_head("hb.e1", 1'b0, 16'h0, 32'h0);
    halt = 1'b0; branch_taken = 1'b0;
    tick(); chk_fetch("hb.e2", 1'b1, 32'h0); chk_head("hb.e2", 1'b0, 16'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
